// File: rtl/carry_accum_pkg.sv
// Shared definitions for carry_accum: FSM state encoding and sample/counter widths.
package carry_accum_pkg;
  localparam int SAMPLE_W = 2;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/sat_add.sv
// Overflow-aware add of a 2-bit sample into a WIDTH-bit sum; carry flags overflow,
// SATURATE selects clamp-to-max versus modulo wrap.
module sat_add
  import carry_accum_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 1
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [SAMPLE_W-1:0] b,
  output logic [WIDTH-1:0]    sum,
  output logic                carry
);
  logic [WIDTH:0] full;

  assign full  = {1'b0, a} + (WIDTH+1)'(b);
  assign carry = full[WIDTH];
  assign sum   = ((SATURATE != 0) && carry) ? {WIDTH{1'b1}} : full[WIDTH-1:0];
endmodule

// File: rtl/carry_accum.sv
// Frame accumulator: sums COUNT accepted 2-bit samples, then holds the result until taken.
// Optional formal properties are compiled in when CARRY_ACCUM_FORMAL_EN is defined.
module carry_accum
  import carry_accum_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int COUNT    = 4,
  parameter int SATURATE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_ovf,
  input  logic                out_ready
);
  localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

  state_t             state;
  logic [WIDTH-1:0]   sum;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic               accept;
  logic [WIDTH-1:0]   add_sum;
  logic               add_carry;
  logic [CNT_W-1:0]   cnt_inc;

  sat_add #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_add (
    .a     (sum),
    .b     (in_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // HOLD only accepts when the held result is being taken in the same cycle.
  assign in_ready  = (state != HOLD) || out_ready;
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt + 8'd1;
  assign out_valid = (state == HOLD);
  assign out_data  = sum;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sum   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            sum   <= WIDTH'(in_data);
            cnt   <= 8'd1;
            ovf   <= 1'b0;
            state <= (COUNT_C == 8'd1) ? HOLD : ACCUM;
          end else if (state == HOLD && out_ready) begin
            state <= IDLE;
          end
        end
        ACCUM: begin
          if (accept) begin
            sum   <= add_sum;
            cnt   <= cnt_inc;
            ovf   <= ovf | add_carry;
            state <= (cnt_inc == COUNT_C) ? HOLD : ACCUM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CARRY_ACCUM_FORMAL_EN
  logic f_init_done = 1'b0;

  always_ff @(posedge clk) f_init_done <= 1'b1;

  always_comb begin
    assume (in_data <= 2'd3);
    assert (cnt <= COUNT_C);
    if (!f_init_done) begin
      assume (!rst_n);
      assert (state == IDLE && sum == '0 && cnt == '0 && !ovf);
    end
  end

  assume property (@(posedge clk) out_valid |-> s_eventually out_ready);

  assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_ovf)));

  assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> s_eventually out_valid);
`endif
endmodule

// File: tb/tb_carry_accum.sv
// Self-checking bench for carry_accum: directed scenarios plus randomized traffic
// compared against a frame-level arithmetic model.
module tb_carry_accum;
  localparam int W = 8;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, in_ready, out_valid, out_ovf;
  logic [1:0] in_data;
  logic [W-1:0] out_data;

  // Small instances for the overflow boundary: WIDTH=3, COUNT=3, saturate and wrap.
  logic       s_in_valid, s_out_ready;
  logic [1:0] s_in_data;
  logic       s1_in_ready, s1_out_valid, s1_out_ovf;
  logic       s0_in_ready, s0_out_valid, s0_out_ovf;
  logic [2:0] s1_out_data, s0_out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  carry_accum #(.WIDTH(W), .COUNT(N), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ovf(out_ovf), .out_ready(out_ready)
  );

  carry_accum #(.WIDTH(3), .COUNT(3), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s1_in_ready), .out_valid(s1_out_valid), .out_data(s1_out_data),
    .out_ovf(s1_out_ovf), .out_ready(s_out_ready)
  );

  carry_accum #(.WIDTH(3), .COUNT(3), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s0_in_ready), .out_valid(s0_out_valid), .out_data(s0_out_data),
    .out_ovf(s0_out_ovf), .out_ready(s_out_ready)
  );

  // Frame result from the true integer sum of the samples.
  function automatic void ref_frame(input int s, input int w, input bit sat,
                                    output int data, output bit ovf);
    int maxv;
    maxv = (1 << w) - 1;
    ovf  = (s > maxv);
    data = ovf ? (sat ? maxv : (s % (1 << w))) : s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 2'd0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = 2'd0; s_out_ready = 1'b0;
    #12;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: valid=%b data=%0d ovf=%b ready=%b want 0 0 0 1",
               out_valid, out_data, out_ovf, in_ready);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int vals[4] = '{1, 2, 3, 3};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 2'(vals[i]);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL basic_early_valid: got %b want 0 at sample %0d", out_valid, i);
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd9 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL basic_result: valid=%b data=%0d ovf=%b want 1 9 0", out_valid, out_data, out_ovf);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_idle: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 2'd3;
      step();
    end
    // Keep offering samples: none may be taken while the result is held.
    in_data = 2'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'd12 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold: cyc=%0d valid=%b data=%0d ovf=%b ready=%b want 1 12 0 0",
                 i, out_valid, out_data, out_ovf, in_ready);
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      bad++; $display("FAIL backpressure_release: ready=%b valid=%b want 1 1", in_ready, out_valid);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL backpressure_idle: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_simultaneous();
    int vals[4] = '{1, 2, 3, 3};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 2'(vals[i]);
      step();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd9) begin
      bad++; $display("FAIL simul_hold: valid=%b data=%0d want 1 9", out_valid, out_data);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 2'd2;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL simul_ready: got %b want 1", in_ready);
    end
    step();
    // New frame already holds one sample (2); three more complete it.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 2'd1;
      #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL simul_no_bubble: step=%0d valid=%b want 0", i, out_valid);
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd5 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL simul_next_frame: valid=%b data=%0d ovf=%b want 1 5 0", out_valid, out_data, out_ovf);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 2'd2;
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_async: valid=%b data=%0d ovf=%b ready=%b want 0 0 0 1",
               out_valid, out_data, out_ovf, in_ready);
    end
    #1 rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 2'd1;
      step();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd4 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL reset_mid_frame: valid=%b data=%0d ovf=%b want 1 4 0", out_valid, out_data, out_ovf);
    end
    step();
  endtask

  task automatic test_overflow();
    int pats[2][3] = '{'{3, 3, 1}, '{3, 3, 3}};
    int sdata, wdata;
    bit sovf, wovf;
    s_out_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        s_in_valid = 1'b1; s_in_data = 2'(pats[p][i]);
        step();
      end
      s_in_valid = 1'b0;
      ref_frame(pats[p][0] + pats[p][1] + pats[p][2], 3, 1'b1, sdata, sovf);
      ref_frame(pats[p][0] + pats[p][1] + pats[p][2], 3, 1'b0, wdata, wovf);
      #1;
      total++;
      if (s1_out_valid !== 1'b1 || s1_out_data !== 3'(sdata) || s1_out_ovf !== sovf) begin
        bad++; $display("FAIL overflow_sat: pat=%0d valid=%b data=%0d ovf=%b want 1 %0d %b",
                        p, s1_out_valid, s1_out_data, s1_out_ovf, sdata, sovf);
      end
      total++;
      if (s0_out_valid !== 1'b1 || s0_out_data !== 3'(wdata) || s0_out_ovf !== wovf) begin
        bad++; $display("FAIL overflow_wrap: pat=%0d valid=%b data=%0d ovf=%b want 1 %0d %b",
                        p, s0_out_valid, s0_out_data, s0_out_ovf, wdata, wovf);
      end
      step();
    end
  endtask

  task automatic test_random();
    int  q[$];
    bit  hold = 1'b0;
    int  exp_data = 0;
    bit  exp_ovf = 1'b0;
    bit  exp_rdy, acc;
    int  s;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = !hold || out_ready;
      total++;
      if (out_valid !== hold || in_ready !== exp_rdy) begin
        bad++; $display("FAIL random_handshake: cyc=%0d valid=%b ready=%b want %b %b",
                        c, out_valid, in_ready, hold, exp_rdy);
      end
      if (hold) begin
        total++;
        if (out_data !== W'(exp_data) || out_ovf !== exp_ovf) begin
          bad++; $display("FAIL random_result: cyc=%0d data=%0d ovf=%b want %0d %b",
                          c, out_data, out_ovf, exp_data, exp_ovf);
        end
      end
      acc = in_valid && exp_rdy;
      if (hold && out_ready) hold = 1'b0;
      if (acc) begin
        q.push_back(int'(in_data));
        if (q.size() == N) begin
          s = 0;
          foreach (q[k]) s += q[k];
          ref_frame(s, W, 1'b1, exp_data, exp_ovf);
          hold = 1'b1;
          q.delete();
        end
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
